// File: rtl/code_defs_pkg.sv
// Shared 64b/66b line-code definitions: sync header values and the
// block-lock state encoding used by the RX PCS.
package code_defs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTL  = 2'b01;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP,
    SLIP_WAIT_ST
  } lock_state_t;

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b block-boundary lock: tests sync headers in fixed windows and
// requests one-bit gearbox slips until a clean window is seen.
module rx_block_lock
  import code_defs_pkg::*;
#(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32
) (
  input  logic       i_rxc,
  input  logic       i_reset,
  input  logic       i_init_done,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_valid,
  output logic       o_slip,
  output logic       o_block_lock
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVLD_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
  localparam logic [IW-1:0] INVLD_MAX = IW'(SH_INVLD_MAX);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(SLIP_WAIT);

  lock_state_t   state_q, state_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic [IW-1:0] sh_invld_cnt_q, sh_invld_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          lock_q, lock_d;
  logic          slip_q, slip_d;

  logic          hdr_bad;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] invld_inc;
  logic [WW-1:0] wait_inc;

  assign hdr_bad   = (i_rx_header != SYNC_DATA) && (i_rx_header != SYNC_CTL);
  assign cnt_inc   = sh_cnt_q + 1'b1;
  assign invld_inc = sh_invld_cnt_q + IW'(hdr_bad);
  assign wait_inc  = wait_cnt_q + 1'b1;

  always_ff @(posedge i_rxc) begin
    if (i_reset) begin
      state_q        <= LOCK_INIT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      lock_q         <= 1'b0;
      slip_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      lock_q         <= lock_d;
      slip_q         <= slip_d;
    end
  end

  // Slip is registered together with entry to SLIP, so the pulse lasts
  // exactly the one cycle spent in that state.
  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    lock_d         = lock_q;
    slip_d         = 1'b0;

    unique case (state_q)
      LOCK_INIT: begin
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
        wait_cnt_d     = '0;
        lock_d         = 1'b0;
        state_d        = TEST_SH;
      end

      TEST_SH: begin
        if (i_rx_valid) begin
          if (!lock_q) begin
            if (hdr_bad) begin
              state_d        = SLIP;
              slip_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else if (cnt_inc == CNT_MAX) begin
              lock_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d = cnt_inc;
            end
          end else begin
            // Losing lock outranks a window completing on the same header.
            if (invld_inc == INVLD_MAX) begin
              state_d        = SLIP;
              slip_d         = 1'b1;
              lock_d         = 1'b0;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else if (cnt_inc == CNT_MAX) begin
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d       = cnt_inc;
              sh_invld_cnt_d = invld_inc;
            end
          end
        end
      end

      SLIP: begin
        state_d        = SLIP_WAIT_ST;
        lock_d         = 1'b0;
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
        wait_cnt_d     = '0;
      end

      SLIP_WAIT_ST: begin
        if (wait_inc >= WAIT_MAX) begin
          state_d        = TEST_SH;
          wait_cnt_d     = '0;
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      default: state_d = LOCK_INIT;
    endcase

    if (!i_init_done) begin
      state_d        = LOCK_INIT;
      sh_cnt_d       = '0;
      sh_invld_cnt_d = '0;
      wait_cnt_d     = '0;
      lock_d         = 1'b0;
      slip_d         = 1'b0;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: directed lock/slip scenarios and
// randomized traffic compared against a behavioural lock model.
module tb_rx_block_lock;
  import code_defs_pkg::*;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 32;

  logic       i_rxc = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_init_done = 1'b0;
  logic [1:0] i_rx_header = 2'b00;
  logic       i_rx_valid = 1'b0;
  logic       o_slip;
  logic       o_block_lock;

  int checks = 0;
  int errors = 0;

  // Model: a slip blanks the input for the slip cycle plus the wait period.
  bit mActive = 0;
  bit mLocked = 0;
  bit mSlip   = 0;
  int mBlank  = 0;
  int mCnt    = 0;
  int mInv    = 0;

  rx_block_lock #(
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX),
    .SLIP_WAIT   (SLIP_WAIT)
  ) dut (
    .i_rxc       (i_rxc),
    .i_reset     (i_reset),
    .i_init_done (i_init_done),
    .i_rx_header (i_rx_header),
    .i_rx_valid  (i_rx_valid),
    .o_slip      (o_slip),
    .o_block_lock(o_block_lock)
  );

  always #5 i_rxc = ~i_rxc;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] goodHdr();
    return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTL;
  endfunction

  function automatic logic [1:0] badHdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic startSlip();
    mSlip   = 1;
    mLocked = 0;
    mBlank  = 1 + SLIP_WAIT;
    mCnt    = 0;
    mInv    = 0;
  endtask

  task automatic modelStep(input bit rst, input bit init, input bit valid, input logic [1:0] hdr);
    bit bad;
    bad = (hdr != SYNC_DATA) && (hdr != SYNC_CTL);
    if (rst || !init) begin
      mActive = 0; mLocked = 0; mSlip = 0; mBlank = 0; mCnt = 0; mInv = 0;
    end else if (!mActive) begin
      mActive = 1; mSlip = 0;
    end else if (mBlank > 0) begin
      mBlank--; mSlip = 0;
    end else begin
      mSlip = 0;
      if (valid) begin
        if (!mLocked) begin
          if (bad) startSlip();
          else begin
            mCnt++;
            if (mCnt == SH_CNT_MAX) begin mLocked = 1; mCnt = 0; end
          end
        end else begin
          mCnt++;
          if (bad) mInv++;
          if (mInv == SH_INVLD_MAX) startSlip();
          else if (mCnt == SH_CNT_MAX) begin mCnt = 0; mInv = 0; end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit init, input bit valid, input logic [1:0] hdr);
    @(negedge i_rxc);
    i_reset     = rst;
    i_init_done = init;
    i_rx_valid  = valid;
    i_rx_header = hdr;
    @(posedge i_rxc);
    modelStep(rst, init, valid, hdr);
    #1;
    checkOutput("lock", int'(o_block_lock), int'(mLocked));
    checkOutput("slip", int'(o_slip), int'(mSlip));
    checkOutput("slip_and_lock", int'(o_slip & o_block_lock), 0);
  endtask

  initial begin
    int badDiv;
    $display("[TB] rx_block_lock bench start");

    // Reset and first lock with every cycle valid
    repeat (3) applyStimulus(1, 0, 0, 2'b00);
    checkOutput("reset_lock", int'(o_block_lock), 0);
    checkOutput("reset_slip", int'(o_slip), 0);
    applyStimulus(0, 1, 0, 2'b00);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 1, 1, goodHdr());
      if (i == 62) checkOutput("pre_lock", int'(o_block_lock), 0);
    end
    checkOutput("first_lock", int'(o_block_lock), 1);

    // Locked: 15 invalid in a window holds, 16 loses lock
    for (int i = 0; i < 64; i++) applyStimulus(0, 1, 1, (i < 15) ? badHdr() : goodHdr());
    checkOutput("hold_15_invalid", int'(o_block_lock), 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, badHdr());
      if (i == 14) checkOutput("hold_at_15", int'(o_block_lock), 1);
    end
    checkOutput("lose_lock", int'(o_block_lock), 0);
    checkOutput("lose_slip", int'(o_slip), 1);
    applyStimulus(0, 1, 1, goodHdr());
    checkOutput("slip_one_cycle", int'(o_slip), 0);
    for (int i = 0; i < SLIP_WAIT; i++) applyStimulus(0, 1, 1, badHdr());

    // Unlocked: bad header at event 10, wait, then relock
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, goodHdr());
    applyStimulus(0, 1, 1, 2'b11);
    checkOutput("event10_slip", int'(o_slip), 1);
    for (int i = 0; i < 1 + SLIP_WAIT; i++) applyStimulus(0, 1, 1, 2'b00);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 1, 1, goodHdr());
      if (i == 62) checkOutput("relock_pre", int'(o_block_lock), 0);
    end
    checkOutput("relock", int'(o_block_lock), 1);

    // Alternating valid with 2'b00 on idle cycles
    applyStimulus(1, 0, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 1, (i % 2) == 0, ((i % 2) == 0) ? goodHdr() : 2'b00);
      if (i == 125) checkOutput("toggle_pre_lock", int'(o_block_lock), 0);
      if (i == 126) checkOutput("toggle_lock", int'(o_block_lock), 1);
    end

    // Init drop in the slip wait, relock, then reset while locked
    for (int i = 0; i < 64; i++) applyStimulus(0, 1, 1, badHdr());
    applyStimulus(1, 0, 0, 2'b00);
    applyStimulus(0, 1, 0, 2'b00);
    applyStimulus(0, 1, 1, 2'b00);
    checkOutput("drop_slip", int'(o_slip), 1);
    repeat (10) applyStimulus(0, 1, 1, goodHdr());
    applyStimulus(0, 0, 1, goodHdr());
    checkOutput("init_drop_lock", int'(o_block_lock), 0);
    repeat (40) applyStimulus(0, 0, 1, badHdr());
    applyStimulus(0, 1, 1, goodHdr());
    for (int i = 0; i < 64; i++) applyStimulus(0, 1, 1, goodHdr());
    checkOutput("init_relock", int'(o_block_lock), 1);
    applyStimulus(1, 1, 1, goodHdr());
    checkOutput("reset_locked", int'(o_block_lock), 0);

    // Randomized traffic alternating clean and noisy phases
    for (int i = 0; i < 6000; i++) begin
      badDiv = ((i / 500) % 2 == 0) ? 60 : 3;
      applyStimulus($urandom_range(0, 799) == 0, $urandom_range(0, 599) != 0,
                    $urandom_range(0, 3) != 0,
                    ($urandom_range(0, badDiv - 1) == 0) ? badHdr() : goodHdr());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_block_lock.md
RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

Interface
REQ-001 Parameter SH_CNT_MAX, default 64, number of valid-qualified sync headers per test window.
REQ-002 Parameter SH_INVLD_MAX, default 16, invalid headers in one window that cause loss of lock while locked.
REQ-003 Parameter SLIP_WAIT, default 32, i_rxc cycles ignored after each slip pulse while the gearbox realigns.
REQ-004 Clocking is fixed: one clock, i_rxc; reset i_reset is synchronous and active-high.
REQ-005 i_rxc  input  1  RX PCS clock; all state changes on its rising edge.
REQ-006 i_reset  input  1  synchronous active-high reset.
REQ-007 i_init_done  input  1  transceiver init complete; low holds the block in LOCK_INIT.
REQ-008 i_rx_header  input  2  sync header from the RX gearbox.
REQ-009 i_rx_valid  input  1  qualifies i_rx_header; header ignored when low.
REQ-010 o_slip  output  1  one-cycle pulse requesting a one-bit gearbox slip.
REQ-011 o_block_lock  output  1  registered; 1 = 66b block boundary locked; consumed by the decoder stage.

Function
REQ-012 A header is valid iff it equals SYNC_DATA or SYNC_CTL; 2'b00 and 2'b11 are invalid.
REQ-013 Only cycles with i_rx_valid=1 are header events; i_rx_valid=0 cycles change no counter and cause no transition.
REQ-014 States: LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT_ST.
REQ-015 LOCK_INIT: o_block_lock=0, counters cleared; leaves for TEST_SH on the first cycle with i_init_done=1.
REQ-016 TEST_SH: each header event increments sh_cnt; each invalid header also increments sh_invld_cnt.
REQ-017 TEST_SH, unlocked: any invalid header -> SLIP on the next cycle; that header is not counted.
REQ-018 TEST_SH, unlocked: event making sh_cnt equal SH_CNT_MAX with sh_invld_cnt=0 -> o_block_lock=1 on the next cycle; both counters cleared.
REQ-019 TEST_SH, locked: event making sh_invld_cnt equal SH_INVLD_MAX -> o_block_lock=0 and SLIP on the next cycle, regardless of sh_cnt.
REQ-020 TEST_SH, locked: event making sh_cnt equal SH_CNT_MAX with sh_invld_cnt < SH_INVLD_MAX -> both counters cleared; lock held.
REQ-021 If REQ-019 and REQ-020 apply on the same event, REQ-019 wins.
REQ-022 SLIP: o_slip=1 for exactly one cycle, o_block_lock=0, counters cleared; then SLIP_WAIT_ST.
REQ-023 SLIP_WAIT_ST: wait counter counts SLIP_WAIT cycles regardless of i_rx_valid; headers are ignored; then TEST_SH with counters cleared.
REQ-024 i_init_done falling to 0 in any state -> LOCK_INIT on the next cycle; o_block_lock=0; any pending slip is cancelled.
REQ-025 Counter widths: $clog2(SH_CNT_MAX+1) for sh_cnt, $clog2(SH_INVLD_MAX+1) for sh_invld_cnt, $clog2(SLIP_WAIT+1) for the wait counter; no counter wraps past its maximum.
REQ-026 Latency: input event to o_block_lock/o_slip change is exactly one i_rxc cycle.
REQ-027 o_slip=1 never coincides with o_block_lock=1.

Reset
REQ-028 i_reset=1 -> state LOCK_INIT, all counters 0, o_slip=0, o_block_lock=0 on the next edge.
REQ-029 Reset takes priority over all other inputs, including mid-SLIP_WAIT_ST and while locked.

Structure
REQ-030 SYNC_DATA and SYNC_CTL come from code_defs_pkg; the state enum typedef (lock_state_t) is added to code_defs_pkg.
REQ-031 Single module; no sub-modules.
REQ-032 All outputs are driven directly from flops.

Verification
REQ-033 64 valid headers (i_rx_valid=1 every cycle) after init -> o_block_lock rises one cycle after the 64th; o_slip stays 0.
REQ-034 Unlocked, header 2'b11 at event 10 -> o_slip pulses once, next header accepted 32 cycles later, lock after 64 further valid events.
REQ-035 Locked, 15 invalid in a 64-event window -> lock held; 16 invalid within a window -> o_block_lock falls and o_slip pulses on the same cycle.
REQ-036 i_rx_valid toggling 1/0 with 2'b00 on every invalid cycle -> identical lock timing to REQ-033 counted in valid events only.
REQ-037 i_init_done dropped mid-SLIP_WAIT_ST -> LOCK_INIT next cycle, no further o_slip; relock from scratch after i_init_done returns.
REQ-038 i_reset asserted while locked -> o_block_lock=0 next cycle; counters 0.
